// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline types and defaults for the hazard controller
package hazard_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, DIV_WAIT = 1'b1} state_e;
  localparam int MDU_LAT_DEF = 34;
  localparam int DCNT_W = 8;
  function automatic logic src_hit(input logic [4:0] rs, input logic uses, input logic [4:0] rd);
    return uses && (rd != 5'd0) && (rs == rd);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and stall/flush controls between pipeline and hazard unit
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_div;
  logic       ex_branch_taken;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       mdu_busy;
  logic       mdu_done;
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_div, ex_branch_taken,
    input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy, mdu_done
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_div, ex_branch_taken,
    output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy, mdu_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-flush and multi-cycle divide stall control.
// Define HAZARD_PERF_CNT_EN to add stall_cnt_o/flush_cnt_o performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  hazard_ctrl_if.slave     hz
);
  state_e              state_q, state_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush, busy, done;
  logic lu_hit;
  assign lu_hit = hz.ex_mem_read && (src_hit(hz.id_rs1, hz.id_uses_rs1, hz.ex_rd) ||
                                     src_hit(hz.id_rs2, hz.id_uses_rs2, hz.ex_rd));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    if (state_q == RUN) begin
      if (hz.ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hz.ex_div) begin
        state_d      = DIV_WAIT;
        dcnt_d       = DCNT_W'(MDU_LAT - 2);
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
        busy         = 1'b1;
      end else if (lu_hit) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end else if (dcnt_q != '0) begin
      dcnt_d       = dcnt_q - 1'b1;
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
      busy         = 1'b1;
    end else begin
      state_d = RUN;
      busy    = 1'b1;
      done    = 1'b1;
    end
  end
  // outputs forced low while reset is held, whatever the pipeline presents
  assign hz.pc_stall     = rst_ni & pc_stall;
  assign hz.if_id_stall  = rst_ni & if_id_stall;
  assign hz.id_ex_stall  = rst_ni & id_ex_stall;
  assign hz.if_id_flush  = rst_ni & if_id_flush;
  assign hz.id_ex_flush  = rst_ni & id_ex_flush;
  assign hz.ex_mem_flush = rst_ni & ex_mem_flush;
  assign hz.mdu_busy     = rst_ni & busy;
  assign hz.mdu_done     = rst_ni & done;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, pc_stall};
      flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, if_id_flush};
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a queued scoreboard checked by a separate monitor
module tb_hazard_ctrl;
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] DIVS = 8'b1110_0110;
  localparam logic [7:0] DONE = 8'b0000_0011;
  localparam logic [7:0] BR   = 8'b0001_1000;
  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  hazard_ctrl_if hif();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  hazard_ctrl #(.MDU_LAT(34), .CNT_W(32)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt),
`endif
    .hz(hif.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] outs();
    return {hif.pc_stall, hif.if_id_stall, hif.id_ex_stall, hif.if_id_flush,
            hif.id_ex_flush, hif.ex_mem_flush, hif.mdu_busy, hif.mdu_done};
  endfunction
  initial begin : monitor
    exp_t t;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        t = sb.pop_front();
        checks++;
        if (outs() !== t.exp) begin
          errors++;
          $display("FAIL %s: got=%b expected=%b", t.name, outs(), t.exp);
        end
      end
    end
  end
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic dv, input logic br);
    hif.id_rs1 = rs1; hif.id_rs2 = rs2; hif.id_uses_rs1 = u1; hif.id_uses_rs2 = u2;
    hif.ex_rd = rd; hif.ex_mem_read = mr; hif.ex_div = dv; hif.ex_branch_taken = br;
  endtask
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic dv, input logic br,
                      input logic [7:0] e, input string n);
    @(posedge clk);
    #1;
    drive(rs1, rs2, u1, u2, rd, mr, dv, br);
    sb.push_back('{e, n});
  endtask
  task automatic idle(input string n);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE, n);
  endtask
  task automatic direct(input logic [31:0] got, input logic [31:0] exp, input string n);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", n, got, exp);
    end
  endtask
  task automatic run_div_tail(input string n);
    for (int i = 1; i <= 32; i++)
      step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, (i % 8) == 0, DIVS, n);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DONE, {n, "_done"});
    idle({n, "_after"});
  endtask
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin : stim
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    step(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, NONE, "in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle("post_reset");
    step(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, LU, "load_use_rs1");
    idle("load_use_bubble");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DIVS, "div_enter");
    run_div_tail("div");
`ifdef HAZARD_PERF_CNT_EN
    direct(stall_cnt, 32'd34, "stall_cnt");
    direct(flush_cnt, 32'd0, "flush_cnt");
`endif
    step(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, LU, "load_use_rs2");
    step(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, NONE, "unused_src");
    step(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, NONE, "not_load");
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, NONE, "load_x0");
    step(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, BR, "branch_over_lu");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, BR, "branch_over_div");
    idle("after_branch_div");
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, DIVS, "div_over_lu");
    run_div_tail("div2");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DIVS, "div3_enter");
    for (int i = 1; i <= 9; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DIVS, "div3_wait");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.push_back('{NONE, "abort_reset"});
    #1;
    direct({24'd0, outs()}, 32'd0, "async_reset_now");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, NONE, "abort_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("no_done_after_abort");
    step(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, LU, "run_after_abort");
    idle("final_idle");
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 34, total EX-stage occupancy in cycles of a DIV/DIVU/REM/REMU (legal 2..255).
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 ID_RS1, ID_RS2  in  5 each  source registers of the instruction in ID.
REQ-006 ID_USES_RS1, ID_USES_RS2  in  1 each  the ID instruction actually reads that source.
REQ-007 EX_RD  in  5  destination register in EX; EX_MEM_READ  in  1  EX instruction is a load.
REQ-008 EX_DIV  in  1  EX instruction is a multi-cycle divide/remainder.
REQ-009 EX_BRANCH_TAKEN  in  1  branch/jump resolved taken in EX.
REQ-010 PC_STALL, IF_ID_STALL, ID_EX_STALL  out  1 each  hold the PC or that pipeline register.
REQ-011 IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  out  1 each  load a bubble (all controls zero) into that register.
REQ-012 MDU_BUSY  out  1  divider occupies EX; MDU_DONE  out  1  final divide cycle.

Function
REQ-013 States RUN and DIV_WAIT; 8-bit down-counter DCNT.
REQ-014 RUN, EX_BRANCH_TAKEN=1: IF_ID_FLUSH=1, ID_EX_FLUSH=1, all stalls 0; overrides load-use and divide.
REQ-015 RUN, no taken branch, EX_MEM_READ=1, EX_RD!=0, EX_RD matches a used ID source: PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1 for that cycle only.
REQ-016 EX_RD=0 never causes a load-use stall.
REQ-017 RUN, no taken branch, EX_DIV=1: enter DIV_WAIT, DCNT<=MDU_LAT-2; PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_FLUSH, MDU_BUSY all 1 in that same cycle.
REQ-018 DIV_WAIT, DCNT!=0: same outputs as REQ-017, DCNT decrements.
REQ-019 DIV_WAIT, DCNT=0: all stalls/flushes 0, MDU_BUSY=1, MDU_DONE=1; next state RUN so divide advances to EX/MEM at that edge.
REQ-020 Divide therefore holds EX exactly MDU_LAT cycles and inserts MDU_LAT-1 bubbles into EX/MEM.
REQ-021 In DIV_WAIT, EX_DIV, EX_MEM_READ and EX_BRANCH_TAKEN are ignored.
REQ-022 Load-use and divide are exclusive (one EX instruction); if both asserted, divide wins.
REQ-023 All outputs are combinational functions of state, DCNT and inputs; no output registered.

Reset
REQ-024 RST_N low: state RUN, DCNT=0, counters 0 immediately, independent of CLK.
REQ-025 During and right after reset every output is 0; reset in DIV_WAIT aborts the divide with no MDU_DONE.

Configuration
REQ-026 Macro HAZARD_PERF_CNT_EN defined: outputs STALL_CNT and FLUSH_CNT (CNT_W each); STALL_CNT +1 each cycle PC_STALL=1, FLUSH_CNT +1 each cycle IF_ID_FLUSH=1; both wrap at 2^CNT_W.
REQ-027 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-028 State encoding (RUN=0, DIV_WAIT=1) and MDU_LAT default belong in the shared pipeline package.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 Load x5 in EX, ID add x6,x5,x1 -> one cycle PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1, then all 0.
REQ-031 Load x0 in EX, ID reads x0 -> no stall.
REQ-032 DIV in EX, MDU_LAT=34 -> 33 cycles of stalls with EX_MEM_FLUSH=1, then one cycle MDU_DONE=1 with no stall, then RUN.
REQ-033 EX_BRANCH_TAKEN=1 with load-use match present -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0.
REQ-034 RST_N low at DIV_WAIT cycle 10 -> all outputs 0 at once, MDU_DONE never pulses, RUN after release.
REQ-035 With HAZARD_PERF_CNT_EN, REQ-030 plus REQ-032 -> STALL_CNT=34, FLUSH_CNT=0.
